fft_serializer: RTL and testbench

Parallel-to-serial frame converter for the FFT datapath. It accepts a full frame of 2**LOG2_PTS samples in one transfer and emits them one per accepted output beat, in natural or bit-reversed order. It generalises the fixed 8-input shift stage: point count and sample width are parameters, both sides use a valid/ready handshake, and a one-frame skid buffer allows back-to-back frames with no bubble.

---
 rtl/fft_serializer_if.sv | 24 ++
 rtl/fft_serializer.sv | 83 ++++++++
 tb/tb_fft_serializer.sv | 163 ++++++++++++++++
 3 files changed

// File: rtl/fft_serializer_if.sv
// fft_serializer_if: frame-in / sample-out handshake bundle for fft_serializer
interface fft_serializer_if #(
  parameter int DATA_W   = 8,
  parameter int LOG2_PTS = 3
);
  localparam int PTS = 1 << LOG2_PTS;
  logic                  in_valid;
  logic                  in_ready;
  logic [PTS*DATA_W-1:0] in_data;
  logic                  in_bitrev;
  logic                  out_valid;
  logic                  out_ready;
  logic [DATA_W-1:0]     out_data;
  logic [LOG2_PTS-1:0]   out_index;
  logic                  out_last;
  modport master (
    output in_valid, in_data, in_bitrev, out_ready,
    input  in_ready, out_valid, out_data, out_index, out_last
  );
  modport slave (
    input  in_valid, in_data, in_bitrev, out_ready,
    output in_ready, out_valid, out_data, out_index, out_last
  );
endinterface

// File: rtl/fft_serializer.sv
// fft_serializer: parallel frame to serial samples, natural or bit-reversed order, with one-frame skid buffer
module fft_serializer #(
  parameter int DATA_W   = 8,
  parameter int LOG2_PTS = 3
) (
  input logic clk,
  input logic rst,
  fft_serializer_if.slave bus
);
  localparam int PTS = 1 << LOG2_PTS;
  logic [PTS-1:0][DATA_W-1:0] a_q, a_d, p_q, p_d;
  logic a_mode_q, a_mode_d, p_mode_q, p_mode_d;
  logic act_q, act_d, pend_q, pend_d;
  logic [LOG2_PTS-1:0] cnt_q, cnt_d, rev;
  logic accept, beat, last;
  assign accept = bus.in_valid & !pend_q;
  assign beat = act_q & bus.out_ready;
  assign last = act_q & (cnt_q == LOG2_PTS'(PTS - 1));
  assign bus.in_ready = !pend_q;
  assign bus.out_valid = act_q;
  assign bus.out_last = last;
  assign bus.out_index = a_mode_q ? rev : cnt_q;
  assign bus.out_data = a_q[bus.out_index];
  // mirror the beat counter for bit-reversed readout
  always_comb begin
    rev = '0;
    for (int i = 0; i < LOG2_PTS; i++) rev[i] = cnt_q[LOG2_PTS-1-i];
  end
  // load A from input or P at frame boundaries, park an early frame in P
  always_comb begin
    a_d = a_q;
    a_mode_d = a_mode_q;
    p_d = p_q;
    p_mode_d = p_mode_q;
    act_d = act_q;
    pend_d = pend_q;
    cnt_d = beat ? cnt_q + 1'b1 : cnt_q;
    if (!act_q) begin
      if (accept) begin
        a_d = bus.in_data;
        a_mode_d = bus.in_bitrev;
        cnt_d = '0;
        act_d = 1'b1;
      end
    end else if (beat && last) begin
      cnt_d = '0;
      if (pend_q) begin
        a_d = p_q;
        a_mode_d = p_mode_q;
        pend_d = 1'b0;
      end else if (accept) begin
        a_d = bus.in_data;
        a_mode_d = bus.in_bitrev;
      end else begin
        act_d = 1'b0;
      end
    end else if (accept) begin
      p_d = bus.in_data;
      p_mode_d = bus.in_bitrev;
      pend_d = 1'b1;
    end
  end
  // state registers; reset discards both buffers
  always_ff @(posedge clk) begin
    if (rst) begin
      a_q <= '0;
      a_mode_q <= 1'b0;
      p_q <= '0;
      p_mode_q <= 1'b0;
      act_q <= 1'b0;
      pend_q <= 1'b0;
      cnt_q <= '0;
    end else begin
      a_q <= a_d;
      a_mode_q <= a_mode_d;
      p_q <= p_d;
      p_mode_q <= p_mode_d;
      act_q <= act_d;
      pend_q <= pend_d;
      cnt_q <= cnt_d;
    end
  end
endmodule

// File: tb/tb_fft_serializer.sv
// tb_fft_serializer: directed checks of ordering, skid buffering, backpressure and reset
module tb_fft_serializer;
  localparam int DATA_W = 8;
  localparam int LOG2_PTS = 3;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int errors = 0;
  int checks = 0;
  int rev_tab[8] = '{0, 4, 2, 6, 1, 5, 3, 7};
  fft_serializer_if #(.DATA_W(DATA_W), .LOG2_PTS(LOG2_PTS)) bus ();
  fft_serializer #(.DATA_W(DATA_W), .LOG2_PTS(LOG2_PTS)) dut (.clk(clk), .rst(rst), .bus(bus));
  always #5 clk = ~clk;
  function automatic logic [63:0] frame(input logic [7:0] base);
    logic [63:0] f;
    for (int k = 0; k < 8; k++) f[k*8 +: 8] = base + 8'(k);
    return f;
  endfunction
  task automatic step();
    @(posedge clk);
    #1;
  endtask
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask
  task automatic test_reset();
    rst = 1'b1;
    bus.in_valid = 1'b0;
    bus.in_data = '0;
    bus.in_bitrev = 1'b0;
    bus.out_ready = 1'b1;
    step();
    step();
    rst = 1'b0;
    chk("reset out_valid", 32'(bus.out_valid), 0);
    chk("reset in_ready", 32'(bus.in_ready), 1);
    chk("reset out_data", 32'(bus.out_data), 0);
    chk("reset out_index", 32'(bus.out_index), 0);
    chk("reset out_last", 32'(bus.out_last), 0);
  endtask
  task automatic test_natural();
    bus.in_valid = 1'b1;
    bus.in_data = frame(8'h10);
    bus.in_bitrev = 1'b0;
    step();
    bus.in_valid = 1'b0;
    for (int k = 0; k < 8; k++) begin
      chk("nat out_valid", 32'(bus.out_valid), 1);
      chk("nat out_data", 32'(bus.out_data), 32'h10 + k);
      chk("nat out_last", 32'(bus.out_last), 32'(k == 7));
      step();
    end
    chk("nat idle", 32'(bus.out_valid), 0);
  endtask
  task automatic test_bitrev();
    bus.in_valid = 1'b1;
    bus.in_data = frame(8'h10);
    bus.in_bitrev = 1'b1;
    step();
    bus.in_valid = 1'b0;
    for (int k = 0; k < 8; k++) begin
      chk("rev out_index", 32'(bus.out_index), rev_tab[k]);
      chk("rev out_data", 32'(bus.out_data), 32'h10 + rev_tab[k]);
      chk("rev out_last", 32'(bus.out_last), 32'(k == 7));
      step();
    end
    chk("rev idle", 32'(bus.out_valid), 0);
  endtask
  task automatic test_back_to_back();
    bus.in_valid = 1'b1;
    bus.in_data = frame(8'h20);
    bus.in_bitrev = 1'b0;
    step();
    for (int b = 0; b < 16; b++) begin
      if (b == 0) begin
        chk("b2b in_ready free", 32'(bus.in_ready), 1);
        bus.in_data = frame(8'h30);
        bus.in_bitrev = 1'b1;
      end
      if (b == 1) begin
        bus.in_valid = 1'b0;
        chk("b2b in_ready full", 32'(bus.in_ready), 0);
      end
      chk("b2b out_valid", 32'(bus.out_valid), 1);
      chk("b2b out_data", 32'(bus.out_data), b < 8 ? 32'h20 + b : 32'h30 + rev_tab[b-8]);
      chk("b2b out_last", 32'(bus.out_last), 32'(b == 7 || b == 15));
      step();
    end
    chk("b2b idle", 32'(bus.out_valid), 0);
  endtask
  task automatic test_backpressure();
    bus.in_valid = 1'b1;
    bus.in_data = frame(8'h10);
    bus.in_bitrev = 1'b0;
    step();
    bus.in_valid = 1'b0;
    step();
    step();
    bus.out_ready = 1'b0;
    bus.in_valid = 1'b1;
    bus.in_data = frame(8'h50);
    for (int s = 0; s < 3; s++) begin
      chk("bp held out_data", 32'(bus.out_data), 32'h12);
      chk("bp held out_index", 32'(bus.out_index), 2);
      if (s > 0) chk("bp third refused", 32'(bus.in_ready), 0);
      step();
      if (s == 0) bus.in_data = frame(8'h60);
    end
    bus.out_ready = 1'b1;
    for (int k = 2; k < 8; k++) begin
      chk("bp resume out_data", 32'(bus.out_data), 32'h10 + k);
      chk("bp third refused", 32'(bus.in_ready), 0);
      step();
    end
    chk("bp next frame data", 32'(bus.out_data), 32'h50);
    chk("bp next frame index", 32'(bus.out_index), 0);
    chk("bp in_ready reopened", 32'(bus.in_ready), 1);
    bus.in_valid = 1'b0;
    for (int k = 0; k < 8; k++) step();
    chk("bp idle", 32'(bus.out_valid), 0);
  endtask
  task automatic test_reset_mid();
    bus.in_valid = 1'b1;
    bus.in_data = frame(8'h10);
    bus.in_bitrev = 1'b0;
    step();
    bus.in_data = frame(8'h50);
    step();
    bus.in_valid = 1'b0;
    step();
    step();
    step();
    chk("mid beat4 data", 32'(bus.out_data), 32'h14);
    chk("mid P full", 32'(bus.in_ready), 0);
    rst = 1'b1;
    step();
    rst = 1'b0;
    chk("mid out_valid", 32'(bus.out_valid), 0);
    chk("mid in_ready", 32'(bus.in_ready), 1);
    bus.in_valid = 1'b1;
    bus.in_data = frame(8'h40);
    step();
    bus.in_valid = 1'b0;
    for (int k = 0; k < 8; k++) begin
      chk("mid new out_data", 32'(bus.out_data), 32'h40 + k);
      step();
    end
    chk("mid idle", 32'(bus.out_valid), 0);
  endtask
  initial begin
    test_reset();
    test_natural();
    test_bitrev();
    test_back_to_back();
    test_backpressure();
    test_reset_mid();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
